// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage: NOP encoding, RS/RT field positions,
// fetch FSM state encoding and the default reset PC.
package if_id_stage_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush insert a NOP bubble, load captures
// the fetched PC/instruction, otherwise the contents hold bit-identical.
module if_id_reg
    import if_id_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    // Flush outranks load; pc is left alone on a bubble since valid_o marks it dead.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i) begin
            inst_d  = INST_W'(NOP_INST);
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= INST_W'(NOP_INST);
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage + IF/ID register: owns the PC, one-cycle fetch latency, stall freezes
// PC and IF/ID, EX branch redirects and flushes. IF_ID_PERF_CNT_EN adds stall/flush counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] inst_mem_addr,
    input  logic [INST_W-1:0] inst_mem_data,
    output logic [ADDR_W-1:0] pc_id,
    output logic [ADDR_W-1:0] pc_plus4_id,
    output logic [INST_W-1:0] inst_id,
    output logic              valid_id,
    output logic [4:0]        rs_id,
    output logic [4:0]        rt_id
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              load;
    logic              flush;
    logic              unused_tgt_lsb;

    assign unused_tgt_lsb = ^branch_target[1:0];

    // Branch outranks stall in both RUN and HOLD; BOOT just burns one cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = {branch_target[ADDR_W-1:2], 2'b00};
                    flush   = 1'b1;
                    state_d = S_RUN;
                end else if (stall) begin
                    state_d = S_HOLD;
                end else begin
                    pc_d    = pc_q + ADDR_W'(4);
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flush_i (flush),
        .pc_i    (pc_q),
        .inst_i  (inst_mem_data),
        .pc_o    (pc_id),
        .inst_o  (inst_id),
        .valid_o (valid_id)
    );

    assign inst_mem_addr = pc_q;
    assign pc_plus4_id   = pc_id + ADDR_W'(4);
    assign rs_id         = inst_id[RS_HI:RS_LO];
    assign rt_id         = inst_id[RT_HI:RT_LO];

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Counters saturate rather than wrap so long runs never read as short ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall && !branch_taken && !(&stall_cycles_q))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (branch_taken && !(&flush_count_q))
                flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
